// File: rtl/edge_pkg.sv
// Shared definitions for the edge event unit: edge-mode encoding and the
// transition qualifier used by every channel.
package edge_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t EDGE_FALL = 2'd0;
    localparam edge_mode_t EDGE_RISE = 2'd1;
    localparam edge_mode_t EDGE_BOTH = 2'd2;

    // True when the accepted transition old_level -> new_level is one the
    // selected mode reports. An unchanged level never qualifies.
    function automatic logic edge_qualifies(edge_mode_t mode, logic old_level, logic new_level);
        logic rise;
        logic fall;
        rise = !old_level && new_level;
        fall = old_level && !new_level;
        case (mode)
            EDGE_FALL: return fall;
            EDGE_RISE: return rise;
            EDGE_BOTH: return rise || fall;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/edge_event_channel.sv
// One input channel: synchroniser chain, debounce counter, edge qualifier
// and the sticky pending/overrun flags handed to the consuming FSM.
module edge_event_channel
    import edge_pkg::*;
#(
    parameter int         SYNC_STAGES     = 2,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter edge_mode_t MODE            = EDGE_RISE,
    parameter bit         RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic ack,
    output logic level,
    output logic detect,
    output logic pending,
    output logic overrun
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value at which one more mismatching cycle completes the run.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg;
    logic [CW-1:0]          cnt_next;
    logic                   level_reg;
    logic                   level_next;
    logic                   detect_reg;
    logic                   detect_next;
    logic                   pending_reg;
    logic                   pending_next;
    logic                   overrun_reg;
    logic                   overrun_next;
    logic                   s;
    logic                   accept;

    // Debounce, qualification and flag bookkeeping for the next cycle.
    always_comb begin
        s            = sync_reg[SYNC_STAGES-1];
        accept       = (s != level_reg) && (cnt_reg == CNT_LAST);
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        pending_next = pending_reg;
        overrun_next = overrun_reg;

        // A mismatch run restarts whenever the input agrees with the stable
        // level again; the counter stops at CNT_LAST so it cannot wrap.
        if (s == level_reg) begin
            cnt_next = '0;
        end else if (accept) begin
            cnt_next   = '0;
            level_next = s;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end

        detect_next = accept && edge_qualifies(MODE, level_reg, s);

        // An ack in the same cycle as a new event must not lose that event,
        // so the event re-arms pending while the ack still clears overrun.
        if (ack) begin
            pending_next = detect_next;
            overrun_next = 1'b0;
        end else if (detect_next) begin
            pending_next = 1'b1;
            overrun_next = overrun_reg | pending_reg;
        end
    end

    // State registers; reset takes effect immediately and drops any partial count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg    <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_reg     <= '0;
            level_reg   <= RESET_LEVEL;
            detect_reg  <= 1'b0;
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], sig};
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            detect_reg  <= detect_next;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
        end
    end

    assign level   = level_reg;
    assign detect  = detect_reg;
    assign pending = pending_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel key/switch conditioner: one independent edge_event_channel
// per input bit, outputs gathered into per-channel vectors.
module edge_event_unit
    import edge_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 1,
    parameter bit RESET_LEVEL     = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sig,
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] detect,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] overrun
);

    // Reject configurations the channel logic cannot honour.
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
        $error("edge_event_unit: EDGE_MODE must be 0, 1 or 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("edge_event_unit: DEBOUNCE_CYCLES must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("edge_event_unit: SYNC_STAGES must be at least 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("edge_event_unit: CHANNELS must be at least 1");
    end

    localparam edge_mode_t MODE = edge_mode_t'(EDGE_MODE);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        edge_event_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .MODE           (MODE),
            .RESET_LEVEL    (RESET_LEVEL)
        ) u_channel (
            .clk    (clk),
            .rst    (rst),
            .sig    (sig[gi]),
            .ack    (ack[gi]),
            .level  (level[gi]),
            .detect (detect[gi]),
            .pending(pending[gi]),
            .overrun(overrun[gi])
        );
    end

endmodule

// File: tb/tb_edge_event_unit.sv
// Directed bench for edge_event_unit. Two instances: A (rising, reset level 0)
// and B (both edges, reset level 1), both with 2 sync stages and a 4-cycle
// debounce. Expected detect pulses are queued when stimulus is driven and
// matched by a monitor as pulses appear; flags are checked at fixed steps.
module tb_edge_event_unit;

    localparam int S = 2;
    localparam int D = 4;
    localparam int LAT = S + D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sig_a = 4'h0;
    logic [3:0] ack_a = 4'h0;
    logic [3:0] level_a, detect_a, pending_a, overrun_a;
    logic [3:0] sig_b = 4'hF;
    logic [3:0] ack_b = 4'h0;
    logic [3:0] level_b, detect_b, pending_b, overrun_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int dut;
        int ch;
    } exp_t;
    exp_t exp_q[$];

    edge_event_unit #(
        .CHANNELS(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
        .EDGE_MODE(1), .RESET_LEVEL(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .sig(sig_a), .ack(ack_a),
        .level(level_a), .detect(detect_a), .pending(pending_a), .overrun(overrun_a)
    );

    edge_event_unit #(
        .CHANNELS(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
        .EDGE_MODE(2), .RESET_LEVEL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .sig(sig_b), .ack(ack_b),
        .level(level_b), .detect(detect_b), .pending(pending_b), .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; read only on falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int at, input int dut, input int ch);
        exp_t e;
        e.cyc = at;
        e.dut = dut;
        e.ch  = ch;
        exp_q.push_back(e);
    endtask

    // Every detect pulse must match a queued expectation for that exact edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) begin
                    if ((d == 0) ? detect_a[c] : detect_b[c]) begin
                        int idx;
                        idx = -1;
                        foreach (exp_q[k]) begin
                            if (idx < 0 && exp_q[k].cyc == cyc && exp_q[k].dut == d && exp_q[k].ch == c)
                                idx = k;
                        end
                        n_cmp++;
                        assert (idx >= 0) else begin
                            n_bad++;
                            $error("FAIL detect_pulse dut%0d ch%0d: observed pulse at edge %0d, expected none", d, c, cyc);
                        end
                        if (idx >= 0) exp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        int c0;

        // Reset state
        step(3);
        chk("reset_a", {level_a, detect_a, pending_a, overrun_a}, 32'h0000);
        chk("reset_b", {level_b, detect_b, pending_b, overrun_b}, 32'hF000);
        rst = 1'b0;
        step(8);
        chk("idle_a", {level_a, detect_a, pending_a, overrun_a}, 32'h0000);
        chk("idle_b", {level_b, detect_b, pending_b, overrun_b}, 32'hF000);

        // Clean press on A ch0
        c0 = cyc;
        sig_a[0] = 1'b1;
        push(c0 + LAT, 0, 0);
        step(LAT - 1);
        chk("press_level_early", level_a, 4'b0000);
        chk("press_pending_early", pending_a, 4'b0000);
        step(1);
        chk("press_level", level_a, 4'b0001);
        chk("press_detect", detect_a, 4'b0001);
        chk("press_pending", pending_a, 4'b0001);
        step(1);
        chk("press_detect_off", detect_a, 4'b0000);

        // Bounce on A ch1: 3 high, 1 low, then held high
        c0 = cyc;
        sig_a[1] = 1'b1;
        step(3);
        sig_a[1] = 1'b0;
        step(1);
        sig_a[1] = 1'b1;
        push(c0 + 4 + LAT, 0, 1);
        step(LAT - 1);
        chk("bounce_level_early", level_a, 4'b0001);
        step(1);
        chk("bounce_level", level_a, 4'b0011);
        chk("bounce_pending", pending_a, 4'b0011);

        // Overrun on A ch0: release (no rising event), press again without ack
        sig_a[0] = 1'b0;
        step(8);
        chk("release_level", level_a, 4'b0010);
        chk("release_flags", {pending_a, overrun_a}, 8'b0011_0000);
        c0 = cyc;
        sig_a[0] = 1'b1;
        push(c0 + LAT, 0, 0);
        step(LAT);
        chk("overrun_set", {pending_a, overrun_a}, 8'b0011_0001);
        ack_a = 4'b0001;
        step(1);
        ack_a = 4'b0000;
        chk("overrun_ack", {pending_a, overrun_a}, 8'b0010_0000);

        // Ack collides with a new event on A ch1
        sig_a[1] = 1'b0;
        step(8);
        chk("collide_prep_level", level_a, 4'b0001);
        c0 = cyc;
        sig_a[1] = 1'b1;
        push(c0 + LAT, 0, 1);
        step(LAT - 1);
        ack_a = 4'b0010;
        step(1);
        chk("collide_flags", {pending_a, overrun_a}, 8'b0010_0000);
        step(1);
        ack_a = 4'b0000;
        chk("collide_ack_alone", pending_a, 4'b0000);

        // Both-edge mode on B ch2: press (1->0) then release, 10 cycles each
        c0 = cyc;
        sig_b[2] = 1'b0;
        push(c0 + LAT, 1, 2);
        step(10);
        chk("both_press_level", level_b, 4'b1011);
        chk("both_press_flags", {pending_b, overrun_b}, 8'b0100_0000);
        c0 = cyc;
        sig_b[2] = 1'b1;
        push(c0 + LAT, 1, 2);
        step(10);
        chk("both_release_level", level_b, 4'b1111);
        chk("both_release_flags", {pending_b, overrun_b}, 8'b0100_0100);
        ack_b = 4'b0100;
        step(1);
        ack_b = 4'b0000;
        chk("both_ack", {pending_b, overrun_b}, 8'b0000_0000);

        // Simultaneous events on B ch0 and ch3
        c0 = cyc;
        sig_b[0] = 1'b0;
        sig_b[3] = 1'b0;
        push(c0 + LAT, 1, 0);
        push(c0 + LAT, 1, 3);
        step(LAT);
        chk("multi_level", level_b, 4'b0110);
        chk("multi_pending", pending_b, 4'b1001);

        // Reset mid-count: A ch3 counter at 2 when rst rises
        c0 = cyc;
        sig_a[2] = 1'b1;
        push(c0 + LAT, 0, 2);
        step(LAT + 1);
        chk("prereset_pending", pending_a, 4'b0100);
        sig_a[3] = 1'b1;
        step(S + 2);
        rst = 1'b1;
        sig_a = 4'h0;
        sig_b = 4'hF;
        #1;
        chk("midreset_a", {level_a, detect_a, pending_a, overrun_a}, 32'h0000);
        chk("midreset_b", {level_b, detect_b, pending_b, overrun_b}, 32'hF000);
        step(3);
        rst = 1'b0;
        step(12);
        chk("postreset_a", {level_a, detect_a, pending_a, overrun_a}, 32'h0000);
        chk("postreset_b", {level_b, detect_b, pending_b, overrun_b}, 32'hF000);

        // Every queued pulse must have been seen
        foreach (exp_q[k])
            $error("FAIL missing_pulse dut%0d ch%0d: observed none, expected pulse at edge %0d",
                   exp_q[k].dut, exp_q[k].ch, exp_q[k].cyc);
        chk("scoreboard_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/edge_event_unit.md
# edge_event_unit

Multi-channel input conditioner and successor to the single-bit edge detector. Each channel synchronises an asynchronous input such as a board push-button, debounces it, and detects rising, falling or both edges. Each detected edge is emitted as a one-cycle pulse and also held as a sticky pending flag until the consuming FSM (game control) acknowledges it. It sits between the board key/switch pins and the BlackJack control logic.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flop depth per channel (≥2).
- `DEBOUNCE_CYCLES`, 16: consecutive cycles of a new level required before it is accepted (≥1).
- `EDGE_MODE`, 1: edge type detected. 0 = falling, 1 = rising, 2 = both. Applies to all channels.
- `RESET_LEVEL`, 1: reset value of the synchroniser and stable level (1 suits active-low keys).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sig` input CHANNELS: raw asynchronous inputs.
- `ack` input CHANNELS: per-channel clear of `pending`/`overrun`; sampled synchronously.
- `level` output CHANNELS: debounced stable level.
- `detect` output CHANNELS: one-cycle edge pulse.
- `pending` output CHANNELS: sticky event flag.
- `overrun` output CHANNELS: sticky flag, set when an event arrives while `pending` is already set.

## Operation
- Reset (async, immediate): synchroniser flops and `level` = RESET_LEVEL; counters = 0; `detect`, `pending`, `overrun` = 0. No edge is reported on reset release while the input equals RESET_LEVEL.
- Synchroniser: SYNC_STAGES-deep shift chain per channel; `s` = last stage.
- Debounce, per channel:
  - Counter width $clog2(DEBOUNCE_CYCLES+1); it never wraps.
  - If `s == level`, the counter clears to 0.
  - If `s != level` and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If `s != level` and counter == DEBOUNCE_CYCLES-1, `level` <= `s` and the counter clears.
  - A mismatch run shorter than DEBOUNCE_CYCLES is discarded with no output effect.
- Edge qualification uses the accepted transition (old `level`, new `s`):
  - rising = 0→1, falling = 1→0.
  - `detect` <= qualifying transition per EDGE_MODE; otherwise `detect` <= 0. It is never high two consecutive cycles.
- Pending/overrun, per channel, on each edge:
  - If `detect` is being set and `pending` = 0, `pending` <= 1.
  - If `detect` is being set and `pending` = 1, `overrun` <= 1 and `pending` stays 1.
  - If `ack` is high and no new event arrives, `pending` <= 0 and `overrun` <= 0.
  - If `ack` and a new event arrive in the same cycle, the new event wins: `pending` stays 1, `overrun` <= 0. No event is lost.
- Channels are fully independent; simultaneous events on several channels are all recorded.

## Timing
- Latency: `sig` change captured at edge 1 → `level`/`detect` update at edge SYNC_STAGES+DEBOUNCE_CYCLES. `pending` rises on the same edge as `detect`.
- With defaults this is 18 cycles.
- `ack` → `pending` low on the next edge; no combinational path from `ack` to outputs.
- All outputs are registered.
- Reset asserted mid-count returns the channel to its reset state at once. The partial count is lost and no pulse is produced.
- A new level is accepted only after a further full DEBOUNCE_CYCLES run following the previous acceptance.

## Structure
- Shared package `edge_pkg`:
  - `EDGE_FALL`=0, `EDGE_RISE`=1, `EDGE_BOTH`=2 constants.
  - `edge_mode_t` 2-bit typedef.
- Sub-module `edge_event_channel`: synchroniser, debounce counter, qualifier and pending/overrun for one bit.
- Top level generates CHANNELS instances and concatenates their outputs.
- Illegal EDGE_MODE (3) or DEBOUNCE_CYCLES=0 is a elaboration-time error.

## Test plan
- Clean press (S=2, D=4, RISE, RESET_LEVEL=0): `sig[0]` 0→1 at edge 1 and held → `level[0]`, `detect[0]` and `pending[0]` go high at edge 6. `detect` is low at edge 7.
- Bounce: `sig[1]` high for 3 cycles, low for 1, then high for 6 (D=4) → exactly one `detect[1]`, 4 cycles after the final stable run begins in `s`. No pulse for the 3-cycle glitch.
- Both mode (EDGE_BOTH): press then release, each held 10 cycles → two `detect` pulses, one per transition. `level` follows.
- Ack collision: second event's `detect` in the same cycle as `ack` → `pending` stays 1, `overrun` 0. `ack` alone next cycle → `pending` 0.
- Overrun: two accepted edges with no `ack` → `overrun` = 1 after the second. `ack` clears both flags the next cycle.
- Reset mid-operation: assert `rst` when counter = 2 of D=4 → all outputs 0 and `level` = RESET_LEVEL immediately. After release with `sig` = RESET_LEVEL, no pulse.
